// File: rtl/algorithm_range_pkg.sv
// Shared primitives for the range generator: default data width, boolean
// constants and the layout of the state debug port.
package algorithm_range_pkg;

    localparam int   INTN_DEFAULT = 8;
    localparam logic TRUE         = 1'b1;
    localparam logic FALSE        = 1'b0;
    localparam int   STATE_W      = 2;

endpackage

// File: rtl/algorithm_range.sv
// Range generator: accepts (start, count), streams start, start+1, ... for
// count elements (mod 2^intN), then reports end = start + count.
//
// Handshakes: a transfer happens on a rising edge where the producer's
// valid and the consumer's ready are both 1. Valid never depends on ready
// in the same cycle, and once raised it stays high, with its data stable,
// until that transfer happens.
module algorithm_range
    import algorithm_range_pkg::*;
#(
    parameter int intN = INTN_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [intN-1:0]    start,
    input  logic [intN-1:0]    count,
    output logic [intN-1:0]    sOut,
    output logic               sOut_valid,
    input  logic               sOut_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [intN-1:0]    end_o,
    output logic [STATE_W-1:0] dbg_state_o
);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [intN-1:0]   value_q, value_d;
    logic [intN-1:0]   remaining_q, remaining_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            value_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            remaining_q <= remaining_d;
        end
    end

    // remaining is only decremented in EMIT, where it is never zero, so it
    // cannot underflow; reaching one on a transfer ends the stream.
    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        remaining_d = remaining_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    value_d     = start;
                    remaining_d = count;
                    state_d     = (count != '0) ? S_EMIT : S_DONE;
                end
            end
            S_EMIT: begin
                if (sOut_ready) begin
                    value_d     = value_q + intN'(1);
                    remaining_d = remaining_q - intN'(1);
                    if (remaining_q == intN'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // After the last element the value register already holds start+count,
    // so the stream element and the result share one register.
    assign in_ready    = (state_q == S_IDLE) ? TRUE : FALSE;
    assign sOut_valid  = (state_q == S_EMIT) ? TRUE : FALSE;
    assign out_valid   = (state_q == S_DONE) ? TRUE : FALSE;
    assign sOut        = value_q;
    assign end_o       = value_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_algorithm_range.sv
// Bench for algorithm_range: directed scenarios plus randomized operands and
// back-pressure, checked by a queue-based scoreboard and an independent monitor.
module tb_algorithm_range;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] start;
    logic [W-1:0] count;
    logic [W-1:0] sOut;
    logic         sOut_valid;
    logic         sOut_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] end_o;
    logic [1:0]   dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_s_q[$];
    logic [W-1:0] exp_e_q[$];

    logic mon_en   = 1'b0;
    logic rand_rdy = 1'b0;

    algorithm_range #(.intN(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .start      (start),
        .count      (count),
        .sOut       (sOut),
        .sOut_valid (sOut_valid),
        .sOut_ready (sOut_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .end_o      (end_o),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever a transfer completes on the next edge.
    always @(negedge clk) begin
        if (mon_en && rst === 1'b0) begin
            if (sOut_valid === 1'b1 && out_valid === 1'b1)
                check("both_valid", 32'd1, 32'd0);
            if (sOut_valid === 1'b1 && sOut_ready === 1'b1) begin
                if (exp_s_q.size() == 0) check("spurious_elem", {24'd0, sOut}, 32'hffff_ffff);
                else check("stream_elem", {24'd0, sOut}, {24'd0, exp_s_q.pop_front()});
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_e_q.size() == 0) check("spurious_end", {24'd0, end_o}, 32'hffff_ffff);
                else check("end_value", {24'd0, end_o}, {24'd0, exp_e_q.pop_front()});
            end
        end
    end

    // Random back-pressure when enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            sOut_ready = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) == 0);
        end
    end

    // Reference model: the stream is start+i for i < count, the result start+count.
    task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 2000) begin
            step();
            guard++;
        end
        check("accept_timeout", {31'd0, guard < 2000}, 32'd1);
        for (int i = 0; i < int'(c); i++) exp_s_q.push_back(W'(int'(s) + i));
        exp_e_q.push_back(W'(int'(s) + int'(c)));
        in_valid = 1'b1;
        start    = s;
        count    = c;
        step();
        in_valid = 1'b0;
        start    = $urandom_range(0, 255);
        count    = $urandom_range(0, 255);
    endtask

    // Full-rate run with cycle-exact checks; sOut_ready must already be 1.
    task automatic stream_chk(input logic [W-1:0] s, input logic [W-1:0] c);
        send(s, c);
        for (int i = 0; i < int'(c); i++) begin
            check("emit_valid", {31'd0, sOut_valid}, 32'd1);
            check("emit_value", {24'd0, sOut}, {24'd0, W'(int'(s) + i)});
            step();
        end
        check("done_svalid", {31'd0, sOut_valid}, 32'd0);
        check("done_valid", {31'd0, out_valid}, 32'd1);
        check("done_end", {24'd0, end_o}, {24'd0, W'(int'(s) + int'(c))});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_ready", {31'd0, in_ready}, 32'd1);
        check("idle_ovalid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(exp_s_q.size() == 0 && exp_e_q.size() == 0 && in_ready === 1'b1) && n < 4000) begin
            step();
            n++;
        end
        check("drain_timeout", {31'd0, n < 4000}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        start      = '0;
        count      = '0;
        sOut_ready = 1'b0;
        out_ready  = 1'b0;
        step();
        in_valid   = 1'b1;
        sOut_ready = 1'b1;
        out_ready  = 1'b1;
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_svalid", {31'd0, sOut_valid}, 32'd0);
        check("rst_ovalid", {31'd0, out_valid}, 32'd0);
        check("rst_sout", {24'd0, sOut}, 32'd0);
        check("rst_end", {24'd0, end_o}, 32'd0);
        rst        = 1'b0;
        in_valid   = 1'b0;
        sOut_ready = 1'b1;
        out_ready  = 1'b0;
        mon_en     = 1'b1;

        stream_chk(8'd1, 8'd3);
        stream_chk(8'hfe, 8'd3);
        stream_chk(8'd9, 8'd0);

        // Stall while the first element is presented.
        sOut_ready = 1'b0;
        send(8'd5, 8'd2);
        for (int i = 0; i < 2; i++) begin
            check("stall_valid", {31'd0, sOut_valid}, 32'd1);
            check("stall_value", {24'd0, sOut}, 32'd5);
            step();
        end
        sOut_ready = 1'b1;
        check("stall_held", {24'd0, sOut}, 32'd5);
        step();
        check("stall_next", {24'd0, sOut}, 32'd6);
        step();
        check("stall_done", {31'd0, out_valid}, 32'd1);
        check("stall_end", {24'd0, end_o}, 32'd7);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset in the middle of a stream, then an immediate new request.
        send(8'd0, 8'd10);
        step();
        step();
        check("pre_rst_value", {24'd0, sOut}, 32'd2);
        rst = 1'b1;
        exp_s_q.delete();
        exp_e_q.delete();
        step();
        rst = 1'b0;
        check("abort_svalid", {31'd0, sOut_valid}, 32'd0);
        check("abort_ovalid", {31'd0, out_valid}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        stream_chk(8'd3, 8'd1);

        // Completion held off while new operands are offered.
        send(8'd7, 8'd2);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            start    = 8'h55;
            count    = 8'd4;
            check("hold_ovalid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_end", {24'd0, end_o}, 32'd9);
            step();
        end
        in_valid = 1'b0;
        check("hold_last_end", {24'd0, end_o}, 32'd9);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_hold_ready", {31'd0, in_ready}, 32'd1);
        check("post_hold_svalid", {31'd0, sOut_valid}, 32'd0);
        check("post_hold_value", {24'd0, sOut}, 32'd9);

        stream_chk(8'h10, 8'd255);

        // Randomized operands with random back-pressure on both outputs.
        rand_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) send($urandom_range(0, 255), $urandom_range(0, 2));
            else send($urandom_range(0, 255), $urandom_range(0, 20));
        end
        send($urandom_range(0, 255), 8'd255);
        wait_done();
        rand_rdy = 1'b0;
        step();
        sOut_ready = 1'b1;
        out_ready  = 1'b0;
        check("final_s_q_empty", exp_s_q.size(), 32'd0);
        check("final_e_q_empty", exp_e_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
